// File: rtl/multdiv_iterative.sv
// Iterative signed 32-bit multiply/divide unit.
//
// A one-cycle ctrl_MULT or ctrl_DIV pulse latches the operands and starts an
// operation. The unit runs 32 iterations, then spends one cycle in DONE to
// finalize the result. A start sampled at edge k gives a one-cycle
// data_resultRDY pulse between edges k+33 and k+34. A start pulse in any
// state aborts the current operation and restarts with the new operands.
//
// Ports:
//   clock           rising-edge clock
//   reset           asynchronous, active-high reset
//   data_operandA   multiplicand / dividend (two's complement)
//   data_operandB   multiplier / divisor (two's complement)
//   ctrl_MULT       start pulse, multiply (wins if both pulses are high)
//   ctrl_DIV        start pulse, divide
//   data_result     product low word or quotient, held until the next DONE
//   data_exception  overflow or divide-by-zero, held alongside data_result
//   data_resultRDY  one-cycle completion pulse
module multdiv_iterative (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {StIdle, StMult, StDiv, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  count_q, count_d;
  // Multiply: 64-bit accumulator. Divide: partial remainder in [32:0].
  logic [63:0] acc_q, acc_d;
  // Multiply: shifting multiplicand. Divide: divisor in [31:0].
  logic [63:0] mcand_q, mcand_d;
  // Multiply: multiplier, consumed LSB first. Divide: dividend shifted out
  // MSB first, with quotient bits shifted in at the bottom.
  logic [31:0] mplier_q, mplier_d;
  logic        neg_q, neg_d;
  logic        is_div_q, is_div_d;
  logic        div_zero_q, div_zero_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;

  logic        start;
  logic [31:0] mag_a, mag_b;
  logic [32:0] rem_sh, rem_sub;
  logic        rem_ge;
  logic [63:0] prod;
  logic [31:0] quot;
  logic        prod_ovf;

  assign start = ctrl_MULT | ctrl_DIV;

  // Magnitudes; 0x80000000 negates to itself, which reads as 2^31 unsigned.
  assign mag_a = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
  assign mag_b = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;

  // Restoring-division step.
  assign rem_sh  = {acc_q[31:0], mplier_q[31]};
  assign rem_ge  = rem_sh >= {1'b0, mcand_q[31:0]};
  assign rem_sub = rem_sh - {1'b0, mcand_q[31:0]};

  // Finalization.
  assign prod     = neg_q ? (64'd0 - acc_q) : acc_q;
  assign quot     = neg_q ? (32'd0 - mplier_q) : mplier_q;
  // Signed product fits in 32 bits only if bits [63:31] are all equal.
  assign prod_ovf = ~((&prod[63:31]) | ~(|prod[63:31]));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    neg_d      = neg_q;
    is_div_d   = is_div_q;
    div_zero_d = div_zero_q;
    result_d   = result_q;
    exc_d      = exc_q;
    rdy_d      = 1'b0;

    if (start) begin
      state_d    = ctrl_MULT ? StMult : StDiv;
      count_d    = 6'd0;
      acc_d      = 64'd0;
      neg_d      = data_operandA[31] ^ data_operandB[31];
      is_div_d   = ~ctrl_MULT;
      div_zero_d = (data_operandB == 32'd0);
      if (ctrl_MULT) begin
        mcand_d  = {32'd0, mag_a};
        mplier_d = mag_b;
      end else begin
        mcand_d  = {32'd0, mag_b};
        mplier_d = mag_a;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StMult: begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + 6'd1;
          if (count_q == 6'd31) state_d = StDone;
        end
        StDiv: begin
          acc_d    = {31'd0, rem_ge ? rem_sub : rem_sh};
          mplier_d = {mplier_q[30:0], rem_ge};
          count_d  = count_q + 6'd1;
          if (count_q == 6'd31) state_d = StDone;
        end
        StDone: begin
          if (is_div_q) begin
            if (div_zero_q) begin
              result_d = 32'd0;
              exc_d    = 1'b1;
            end else begin
              result_d = quot;
              // Only a positive quotient of 2^31 (0x80000000 / -1) overflows.
              exc_d    = ~neg_q & mplier_q[31];
            end
          end else begin
            result_d = prod[31:0];
            exc_d    = prod_ovf;
          end
          rdy_d   = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= 6'd0;
      acc_q      <= 64'd0;
      mcand_q    <= 64'd0;
      mplier_q   <= 32'd0;
      neg_q      <= 1'b0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      result_q   <= 32'd0;
      exc_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      neg_q      <= neg_d;
      is_div_q   <= is_div_d;
      div_zero_q <= div_zero_d;
      result_q   <= result_d;
      exc_q      <= exc_d;
      rdy_q      <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_iterative.sv
// Self-checking bench for multdiv_iterative: table-driven operation vectors
// plus hand-written restart, back-to-back and reset-mid-operation sequences.
module tb_multdiv_iterative;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  multdiv_iterative dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  typedef struct {
    string       name;
    logic        m;
    logic        d;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start at edge 0, then scramble the operands and watch 36 edges for RDY.
  task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                        input logic [31:0] b, output int cnt, output int at);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
    cnt = 0; at = -1;
    for (int e = 1; e <= 36; e++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        cnt++;
        at = e;
      end
    end
  endtask

  initial begin
    int cnt, at, cnt2, at2;
    logic [31:0] res1;
    logic        exc1;

    vecs[0] = '{"mul_7_m6",     1'b1, 1'b0, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0};
    vecs[1] = '{"mul_ovf",      1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
    vecs[2] = '{"mul_min_1",    1'b1, 1'b0, 32'h80000000, 32'd1,        32'h80000000, 1'b0};
    vecs[3] = '{"mul_m1_m1",    1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    vecs[4] = '{"div_m7_2",     1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
    vecs[5] = '{"div_100_7",    1'b0, 1'b1, 32'd100,      32'd7,        32'h0000000E, 1'b0};
    vecs[6] = '{"div_min_m1",   1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[7] = '{"div_5_0",      1'b0, 1'b1, 32'd5,        32'd0,        32'h00000000, 1'b1};
    vecs[8] = '{"div_min_1",    1'b0, 1'b1, 32'h80000000, 32'd1,        32'h80000000, 1'b0};
    vecs[9] = '{"both_is_mult", 1'b1, 1'b1, 32'd6,        32'd3,        32'd18,       1'b0};

    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = 32'd0; data_operandB = 32'd0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_result", data_result, 32'd0);
    chk("reset_exc", {31'd0, data_exception}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b, cnt, at);
      chk({vecs[i].name, "_rdy_cnt"}, cnt, 32'd1);
      chk({vecs[i].name, "_rdy_at"}, at, 32'd33);
      chk({vecs[i].name, "_result"}, data_result, vecs[i].res);
      chk({vecs[i].name, "_exc"}, {31'd0, data_exception}, {31'd0, vecs[i].exc});
    end

    // Restart: MULT 3*4 at edge 0, DIV 100/7 at edge 10 -> one RDY at 43.
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd4;
    @(posedge clock);
    cnt = 0; at = -1; cnt2 = 0;
    for (int e = 1; e <= 50; e++) begin
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV  = (e == 10);
      data_operandA = (e == 10) ? 32'd100 : 32'd9;
      data_operandB = (e == 10) ? 32'd7 : 32'd9;
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        cnt++;
        at = e;
        if (e == 33) cnt2++;
      end
    end
    ctrl_DIV = 1'b0;
    chk("restart_rdy_cnt", cnt, 32'd1);
    chk("restart_rdy_at", at, 32'd43);
    chk("restart_no_rdy_33", cnt2, 32'd0);
    chk("restart_result", data_result, 32'd14);

    // Back-to-back: DIV started in the cycle RDY is high for MULT 7*-6.
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'd7; data_operandB = 32'hFFFFFFFA;
    @(posedge clock);
    cnt = 0; at = -1; at2 = -1; res1 = 32'd0; exc1 = 1'b1;
    for (int e = 1; e <= 70; e++) begin
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV  = (e == 34);
      data_operandA = (e == 34) ? 32'd100 : 32'd1;
      data_operandB = (e == 34) ? 32'd7 : 32'd1;
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        cnt++;
        if (at < 0) begin
          at = e; res1 = data_result; exc1 = data_exception;
        end else begin
          at2 = e;
        end
      end
    end
    ctrl_DIV = 1'b0;
    chk("b2b_rdy_cnt", cnt, 32'd2);
    chk("b2b_first_at", at, 32'd33);
    chk("b2b_first_result", res1, 32'hFFFFFFD6);
    chk("b2b_first_exc", {31'd0, exc1}, 32'd0);
    chk("b2b_second_at", at2, 32'd67);
    chk("b2b_second_result", data_result, 32'd14);

    // Reset mid-operation: outputs clear at once and no RDY follows.
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd5;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    repeat (20) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("midreset_result", data_result, 32'd0);
    chk("midreset_exc", {31'd0, data_exception}, 32'd0);
    chk("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    cnt = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) cnt++;
    end
    chk("midreset_no_rdy", cnt, 32'd0);
    run_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, cnt, at);
    chk("postreset_rdy_cnt", cnt, 32'd1);
    chk("postreset_rdy_at", at, 32'd33);
    chk("postreset_result", data_result, 32'd1);
    chk("postreset_exc", {31'd0, data_exception}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
